// File: rtl/rc5_stream_if.sv
// Stream bundle between the pin/serial side and the RC5 core port wrapper.
interface rc5_stream_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4
);
  logic [W-1:0]       serial_port_in;
  logic               iInValid;
  logic               iInSof;
  logic               oInReady;
  logic [N_IN*W-1:0]  oParOut;
  logic               oParValid;
  logic               iParReady;
  logic [N_OUT*W-1:0] iParIn;
  logic               iParInValid;
  logic               oParInReady;
  logic [W-1:0]       serial_port_out;
  logic               oOutValid;
  logic               oOutLast;
  logic               iOutReady;
  logic               oRxErr;

  modport slave (
    input  serial_port_in, iInValid, iInSof, iParReady, iParIn, iParInValid, iOutReady,
    output oInReady, oParOut, oParValid, oParInReady, serial_port_out, oOutValid, oOutLast, oRxErr
  );

  modport master (
    output serial_port_in, iInValid, iInSof, iParReady, iParIn, iParInValid, iOutReady,
    input  oInReady, oParOut, oParValid, oParInReady, serial_port_out, oOutValid, oOutLast, oRxErr
  );
endinterface

// File: rtl/rc5_stream_port.sv
// Framed valid/ready port around the RC5 core: deserialises N_IN RX words, serialises N_OUT TX words.
// Define RC5_STREAM_STATS_EN to add RX/TX frame counters and a saturating RX-error counter.
module rc5_stream_port #(
  parameter int unsigned W     = 64,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  rc5_stream_if.slave bus
`ifdef RC5_STREAM_STATS_EN
  ,
  output logic [15:0] oRxFrames,
  output logic [15:0] oTxFrames,
  output logic [7:0]  oRxErrCnt
`endif
);
  localparam int unsigned RX_IW = $clog2(N_IN);
  localparam int unsigned TX_IW = $clog2(N_OUT);
  localparam logic [RX_IW-1:0] RX_LAST = RX_IW'(N_IN - 1);
  localparam logic [TX_IW-1:0] TX_LAST = TX_IW'(N_OUT - 1);

  typedef enum logic {RX_FILL, RX_HOLD} rxState_t;
  typedef enum logic {TX_IDLE, TX_SEND} txState_t;

  rxState_t          rxState, rxStateNext;
  txState_t          txState, txStateNext;
  logic [RX_IW-1:0]  rxIdx, rxIdxNext, rxSlot;
  logic [TX_IW-1:0]  txIdx, txIdxNext;
  logic [W-1:0]      asmReg [N_IN];
  logic [W-1:0]      txBuf [N_OUT];
  logic [N_IN*W-1:0] asmFlat;
  logic              rxWrite, rxLoad, rxErrNext, parConsume;
  logic              txCapture, txFrameDone, txValidNext, txLastNext;
  logic [W-1:0]      txWordNext;

  assign txFrameDone     = bus.oOutValid && bus.iOutReady && bus.oOutLast;
  assign bus.oInReady    = (rxState == RX_FILL);
  assign bus.oParInReady = (txState == TX_IDLE) || txFrameDone;
  assign parConsume      = bus.oParValid && bus.iParReady;
  assign txCapture       = bus.iParInValid && bus.oParInReady;

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxState <= RX_FILL;
      txState <= TX_IDLE;
    end else begin
      rxState <= rxStateNext;
      txState <= txStateNext;
    end
  end

  // RX next-state: slot write, frame hand-off to the output register, truncation detect
  always_comb begin
    rxStateNext = rxState;
    rxIdxNext   = rxIdx;
    rxWrite     = 1'b0;
    rxLoad      = 1'b0;
    rxErrNext   = 1'b0;
    rxSlot      = bus.iInSof ? '0 : rxIdx;
    case (rxState)
      RX_FILL: begin
        if (bus.iInValid) begin
          rxWrite = 1'b1;
          if (bus.iInSof) begin
            rxIdxNext = RX_IW'(1);
            rxErrNext = (rxIdx != '0);
          end else if (rxIdx == RX_LAST) begin
            rxIdxNext = '0;
            if (!bus.oParValid || bus.iParReady) rxLoad = 1'b1;
            else rxStateNext = RX_HOLD;
          end else begin
            rxIdxNext = rxIdx + RX_IW'(1);
          end
        end
      end
      RX_HOLD: begin
        if (parConsume) begin
          rxLoad      = 1'b1;
          rxStateNext = RX_FILL;
        end
      end
      default: rxStateNext = RX_FILL;
    endcase
  end

  // Assembly view including the word being written this cycle, so a frame completes with no bubble
  always_comb begin
    asmFlat = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      asmFlat[k*W +: W] = (rxWrite && (RX_IW'(k) == rxSlot)) ? bus.serial_port_in : asmReg[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rxWrite) asmReg[rxSlot] <= bus.serial_port_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxIdx         <= '0;
      bus.oParOut   <= '0;
      bus.oParValid <= 1'b0;
      bus.oRxErr    <= 1'b0;
    end else begin
      rxIdx      <= rxIdxNext;
      bus.oRxErr <= rxErrNext;
      if (rxLoad) begin
        bus.oParOut   <= asmFlat;
        bus.oParValid <= 1'b1;
      end else if (parConsume) begin
        bus.oParValid <= 1'b0;
      end
    end
  end

  // TX next-state: capture starts a frame, each accepted word advances, last word may chain a capture
  always_comb begin
    txStateNext = txState;
    txIdxNext   = txIdx;
    txValidNext = bus.oOutValid;
    txLastNext  = bus.oOutLast;
    txWordNext  = bus.serial_port_out;
    if (txCapture) begin
      txStateNext = TX_SEND;
      txIdxNext   = '0;
      txValidNext = 1'b1;
      txLastNext  = (TX_LAST == '0);
      txWordNext  = bus.iParIn[W-1:0];
    end else if (txState == TX_SEND && bus.oOutValid && bus.iOutReady) begin
      if (bus.oOutLast) begin
        txStateNext = TX_IDLE;
        txValidNext = 1'b0;
        txLastNext  = 1'b0;
      end else begin
        txIdxNext  = txIdx + TX_IW'(1);
        txLastNext = (txIdxNext == TX_LAST);
        txWordNext = txBuf[txIdxNext];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (txCapture) begin
      for (int unsigned k = 0; k < N_OUT; k++) txBuf[k] <= bus.iParIn[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txIdx               <= '0;
      bus.serial_port_out <= '0;
      bus.oOutValid       <= 1'b0;
      bus.oOutLast        <= 1'b0;
    end else begin
      txIdx               <= txIdxNext;
      bus.serial_port_out <= txWordNext;
      bus.oOutValid       <= txValidNext;
      bus.oOutLast        <= txLastNext;
    end
  end

`ifdef RC5_STREAM_STATS_EN
  // Frame counters wrap; the error counter sticks at its maximum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oRxFrames <= '0;
      oTxFrames <= '0;
      oRxErrCnt <= '0;
    end else begin
      if (rxLoad) oRxFrames <= oRxFrames + 16'd1;
      if (txFrameDone) oTxFrames <= oTxFrames + 16'd1;
      if (bus.oRxErr && (oRxErrCnt != 8'hFF)) oRxErrCnt <= oRxErrCnt + 8'd1;
    end
  end
`endif
endmodule
